// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out stage. Takes a WIDTH-bit word from the register
//   bank q bus and emits it one bit per accepted serial transfer. Valid/ready
//   handshake on both sides. A new word can be loaded on the same edge that
//   the last bit of the current word transfers, so back-to-back words leave
//   no bubble.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no word loaded; in_ready=1, ser_valid=0
//   SHIFT  | word loaded; head bit of r_shift presented on o_ser_out
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   i_in_data    parallel word from the register bank
//   i_in_valid   i_in_data is valid
//   o_in_ready   serializer accepts i_in_data this cycle
//                (combinational from i_ser_ready while in SHIFT)
//   o_ser_out    current serial bit
//   o_ser_valid  o_ser_out is valid
//   i_ser_ready  downstream accepts o_ser_out this cycle
//   o_ser_last   o_ser_out is the final bit of the word
//   o_busy       a word is loaded and not fully emitted
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    input  logic             i_ser_ready,
    output logic             o_ser_last,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic             w_in_shift;
    logic             w_last;
    logic             w_xfer;
    logic             w_accept;
    logic             w_head_bit;
    logic [WIDTH-1:0] w_shift_next;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_xfer     = w_in_shift && i_ser_ready;

    // A word is taken either from IDLE or on the edge where the last bit of
    // the current word leaves; the latter is what gives zero-bubble streaming.
    assign w_accept   = i_in_valid && (!w_in_shift || (w_xfer && w_last));

    // Shift toward the output bit with zero fill.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_head_bit   = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end else begin : g_msb
            assign w_head_bit   = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_shift <= i_in_data;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                // Final bit gone and nothing waiting: clear so IDLE is clean.
                r_state <= ST_IDLE;
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    assign o_ser_valid = w_in_shift;
    assign o_busy      = w_in_shift;
    assign o_ser_out   = w_in_shift && w_head_bit;
    assign o_ser_last  = w_in_shift && w_last;
    assign o_in_ready  = !w_in_shift || (w_xfer && w_last);

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] i_in_data;
    logic       i_in_valid;
    logic       i_ser_ready;

    logic rdy1, out1, val1, last1, busy1;
    logic rdy0, out0, val0, last0, busy0;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(rdy1),
        .o_ser_out(out1), .o_ser_valid(val1), .i_ser_ready(i_ser_ready),
        .o_ser_last(last1), .o_busy(busy1)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(rdy0),
        .o_ser_out(out0), .o_ser_valid(val0), .i_ser_ready(i_ser_ready),
        .o_ser_last(last0), .o_busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the word being emitted and how many of its bits have
    // already left. Bit k of the stream is word[k] (LSB first) or word[7-k].
    logic       m_active;
    logic [7:0] m_word;
    int         m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_word   = 8'h00;
            m_k      = 0;
        end else begin
            if (m_active && i_ser_ready) begin
                if (m_k == 7) begin
                    if (i_in_valid) begin
                        m_word = i_in_data;
                        m_k    = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_k = m_k + 1;
                end
            end else if (!m_active && i_in_valid) begin
                m_active = 1'b1;
                m_word   = i_in_data;
                m_k      = 0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic e_last, e_rdy, e_out1, e_out0;
        e_last = m_active && (m_k == 7);
        e_rdy  = !m_active || (i_ser_ready && m_k == 7);
        e_out1 = m_active && m_word[m_k];
        e_out0 = m_active && m_word[7 - m_k];
        chk("ser_valid", {31'd0, val1},  {31'd0, m_active});
        chk("busy",      {31'd0, busy1}, {31'd0, m_active});
        chk("ser_last",  {31'd0, last1}, {31'd0, e_last});
        chk("in_ready",  {31'd0, rdy1},  {31'd0, e_rdy});
        chk("ser_out_lsb", {31'd0, out1}, {31'd0, e_out1});
        chk("ser_out_msb", {31'd0, out0}, {31'd0, e_out0});
        chk("msb_ctrl", {28'd0, val0, busy0, last0, rdy0}, {28'd0, m_active, m_active, e_last, e_rdy});
    end

    // Capture of transferred bits (bit i = i-th emitted) for literal checks.
    logic [31:0] cap1, cap0, capl;
    int          ncap, vcyc, ircnt;

    always @(negedge clk) begin
        if (val1) begin
            vcyc = vcyc + 1;
            if (rdy1) ircnt = ircnt + 1;
            if (i_ser_ready) begin
                if (ncap < 32) begin
                    cap1[ncap] = out1;
                    cap0[ncap] = out0;
                    capl[ncap] = last1;
                end
                ncap = ncap + 1;
            end
        end
    end

    task automatic clear_cap();
        cap1 = '0; cap0 = '0; capl = '0;
        ncap = 0; vcyc = 0; ircnt = 0;
    endtask

    // Present a word and hold it until the accepting edge; returns #1 after it.
    task automatic put(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = w;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rdy1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("put_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy1 && !busy0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        i_in_data   = 8'h00;
        i_in_valid  = 1'b0;
        i_ser_ready = 1'b1;
        clear_cap();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {27'd0, out1, val1, last1, busy1, rdy1}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LSB first 0xAA -> 0,1,0,1,...; MSB-first instance reverses order
        clear_cap();
        put(8'hAA);
        i_in_valid = 1'b0;
        wait_idle();
        chk("t1_stream_lsb", cap1, 32'h0000_00AA);
        chk("t1_stream_msb", cap0, 32'h0000_0055);
        chk("t1_last_pos",   capl, 32'h0000_0080);
        chk("t1_nbits",      ncap, 32'd8);
        chk("t1_idle", {30'd0, val1, busy1}, 32'd0);

        // MSB first 0xA5 -> 1,0,1,0,0,1,0,1
        clear_cap();
        put(8'hA5);
        i_in_valid = 1'b0;
        wait_idle();
        chk("t2_stream_msb", cap0, 32'h0000_00A5);
        chk("t2_last_pos",   capl, 32'h0000_0080);

        // 3-cycle backpressure after bit 2 is presented
        clear_cap();
        put(8'hCC);
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ser_ready = 1'b1;
        wait_idle();
        chk("t3_cycles",     vcyc, 32'd11);
        chk("t3_stream_lsb", cap1, 32'h0000_00CC);
        chk("t3_stream_msb", cap0, 32'h0000_0033);

        // back-to-back words, in_valid held high across the boundary
        clear_cap();
        put(8'hCC);
        put(8'h33);
        i_in_valid = 1'b0;
        wait_idle();
        chk("t4_stream",  cap1,  32'h0000_33CC);
        chk("t4_cycles",  vcyc,  32'd16);
        chk("t4_rdy_cnt", ircnt, 32'd2);
        chk("t4_last",    capl,  32'h0000_8080);

        // asynchronous reset while bit 3 of 0xFF is presented
        clear_cap();
        put(8'hFF);
        i_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t5_pre_rst", {30'd0, val1, out1}, 32'h3);
        rst = 1'b1;
        #1;
        chk("t5_async", {27'd0, val1, out1, busy1, val0, rdy1}, 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("t5_rst_held", {30'd0, rdy1, busy1}, 32'h2);
        rst = 1'b0;
        clear_cap();
        put(8'h0F);
        i_in_valid = 1'b0;
        wait_idle();
        chk("t5_stream", cap1, 32'h0000_000F);
        chk("t5_nbits",  ncap, 32'd8);

        // in_data changes after the accepting edge must not leak in
        clear_cap();
        put(8'h3C);
        i_in_data  = 8'hFF;
        i_in_valid = 1'b0;
        wait_idle();
        chk("t6_stream_lsb", cap1, 32'h0000_003C);
        chk("t6_stream_msb", cap0, 32'h0000_003C);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            i_in_valid  = ($urandom_range(0, 9) < 6);
            i_in_data   = 8'($urandom);
            i_ser_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        i_in_valid  = 1'b0;
        i_ser_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
